// File: rtl/nanov_operand_loader.sv
// nanoV operand loader: framed bit-serial receiver for the op/a/b buses.
// Optional even parity bit is enabled with NANOV_LOADER_PARITY_EN.
module nanov_operand_loader #(
    parameter int OP_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk12MHz,
    input  logic              rstn,
    input  logic              rx_i,
    output logic [OP_W-1:0]   op_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OP    = 3'd1,
        S_A     = 3'd2,
        S_B     = 3'd3,
`ifdef NANOV_LOADER_PARITY_EN
        S_PAR   = 3'd4,
`endif
        S_STOP  = 3'd5,
        S_BREAK = 3'd6
    } state_t;

    state_t            state_q;
    logic [5:0]        cnt_q;
    logic [OP_W-1:0]   op_s_q, op_s_d;
    logic [DATA_W-1:0] a_s_q, a_s_d;
    logic [DATA_W-1:0] b_s_q, b_s_d;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              valid_q, busy_q, err_q;
    logic              last_op, last_data;
    logic              stop_ok;

`ifdef NANOV_LOADER_PARITY_EN
    logic              par_q;
    logic              perr_q;
`endif

    assign op_o    = op_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;

    assign last_op   = (cnt_q == 6'(OP_W - 1));
    assign last_data = (cnt_q == 6'(DATA_W - 1));

`ifdef NANOV_LOADER_PARITY_EN
    assign stop_ok = rx_i && !perr_q;
`else
    assign stop_ok = rx_i;
`endif

    // Shadow registers shift in the new bit at the LSB (MSB-first order).
    always_comb begin
        op_s_d = (op_s_q << 1) | OP_W'(rx_i);
        a_s_d  = (a_s_q << 1) | DATA_W'(rx_i);
        b_s_d  = (b_s_q << 1) | DATA_W'(rx_i);
    end

    // Frame FSM with registered outputs; commit only on a clean stop bit.
    always_ff @(posedge clk12MHz or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_s_q  <= '0;
            a_s_q   <= '0;
            b_s_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef NANOV_LOADER_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_i) begin
                        state_q <= S_OP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef NANOV_LOADER_PARITY_EN
                        par_q   <= 1'b0;
                        perr_q  <= 1'b0;
`endif
                    end
                end
                S_OP: begin
                    op_s_q <= op_s_d;
`ifdef NANOV_LOADER_PARITY_EN
                    par_q  <= par_q ^ rx_i;
`endif
                    if (last_op) begin
                        state_q <= S_A;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_A: begin
                    a_s_q <= a_s_d;
`ifdef NANOV_LOADER_PARITY_EN
                    par_q <= par_q ^ rx_i;
`endif
                    if (last_data) begin
                        state_q <= S_B;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_B: begin
                    b_s_q <= b_s_d;
`ifdef NANOV_LOADER_PARITY_EN
                    par_q <= par_q ^ rx_i;
`endif
                    if (last_data) begin
                        cnt_q <= '0;
`ifdef NANOV_LOADER_PARITY_EN
                        state_q <= S_PAR;
`else
                        state_q <= S_STOP;
`endif
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
`ifdef NANOV_LOADER_PARITY_EN
                S_PAR: begin
                    perr_q  <= rx_i ^ par_q;
                    state_q <= S_STOP;
                end
`endif
                S_STOP: begin
                    busy_q <= 1'b0;
                    if (stop_ok) begin
                        op_q    <= op_s_q;
                        a_q     <= a_s_q;
                        b_q     <= b_s_q;
                        valid_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_operand_loader.sv
// Directed bench for nanov_operand_loader.
// Frames are driven #1 after each rising edge; outputs are checked there too.
module tb_nanov_operand_loader;

    logic        clk;
    logic        rstn;
    logic        rx;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef NANOV_LOADER_PARITY_EN
    localparam int FL = 71;
    logic pflip = 1'b0;
`else
    localparam int FL = 70;
`endif

    nanov_operand_loader #(
        .OP_W   (4),
        .DATA_W (32)
    ) dut (
        .clk12MHz (clk),
        .rstn     (rstn),
        .rx_i     (rx),
        .op_o     (op),
        .a_o      (a),
        .b_o      (b),
        .valid_o  (valid),
        .busy_o   (busy),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic bt);
        rx = bt;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame; counts cycles where busy/valid/err look wrong mid-frame.
    task automatic send_frame(input logic [3:0]  f_op,
                              input logic [31:0] f_a,
                              input logic [31:0] f_b,
                              input logic        stop,
                              output int         oddc);
        logic [67:0] pl;
        pl = {f_op, f_a, f_b};
        oddc = 0;
        send_bit(1'b0);
        if (!busy || valid || err) oddc++;
        for (int i = 67; i >= 0; i--) begin
            send_bit(pl[i]);
            if (!busy || valid || err) oddc++;
        end
`ifdef NANOV_LOADER_PARITY_EN
        send_bit((^pl) ^ pflip);
        if (!busy || valid || err) oddc++;
`endif
        send_bit(stop);
    endtask

    initial begin
        int oddc;
        int act;
        int t1;
        int t2;
        logic [67:0] pl;

        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op", 64'(op), 64'h0);
        chk("rst_a", 64'(a), 64'h0);
        chk("rst_b", 64'(b), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        rstn = 1'b1;

        act = 0;
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1);
            if (busy || valid || err || op != 0 || a != 0 || b != 0) act++;
        end
        chk("idle_quiet", 64'(act), 64'h0);

        send_frame(4'hA, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, oddc);
        t1 = cyc;
        chk("f1_midframe", 64'(oddc), 64'h0);
        chk("f1_valid", 64'(valid), 64'h1);
        chk("f1_op", 64'(op), 64'hA);
        chk("f1_a", 64'(a), 64'h1234_5678);
        chk("f1_b", 64'(b), 64'hDEAD_BEEF);
        chk("f1_busy", 64'(busy), 64'h0);
        chk("f1_err", 64'(err), 64'h0);

        send_frame(4'h3, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, oddc);
        t2 = cyc;
        chk("f2_midframe", 64'(oddc), 64'h0);
        chk("f2_spacing", 64'(t2 - t1), 64'(FL));
        chk("f2_valid", 64'(valid), 64'h1);
        chk("f2_op", 64'(op), 64'h3);
        chk("f2_a", 64'(a), 64'h0000_0001);
        chk("f2_b", 64'(b), 64'hFFFF_FFFF);
        send_bit(1'b1);
        chk("f2_pulse_len", 64'(valid), 64'h0);
        chk("f2_hold_b", 64'(b), 64'hFFFF_FFFF);

        send_frame(4'hA, 32'h1111_2222, 32'h3333_4444, 1'b1, oddc);
        chk("f3_valid", 64'(valid), 64'h1);
        send_frame(4'h5, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1'b0, oddc);
        chk("e_err", 64'(err), 64'h1);
        chk("e_valid", 64'(valid), 64'h0);
        chk("e_keep_op", 64'(op), 64'hA);
        chk("e_keep_a", 64'(a), 64'h1111_2222);
        chk("e_keep_b", 64'(b), 64'h3333_4444);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0);
            if (busy || valid || err) act++;
        end
        chk("e_break_quiet", 64'(act), 64'h0);
        send_bit(1'b1);
        chk("e_back_idle", 64'(busy), 64'h0);
        send_frame(4'h6, 32'h0F0F_0F0F, 32'hA5A5_5A5A, 1'b1, oddc);
        chk("e_recover_valid", 64'(valid), 64'h1);
        chk("e_recover_op", 64'(op), 64'h6);
        chk("e_recover_b", 64'(b), 64'hA5A5_5A5A);

        pl = {4'h9, 32'h8765_4321, 32'h1357_9BDF};
        send_bit(1'b0);
        for (int i = 67; i > 28; i--) send_bit(pl[i]);
        rstn = 1'b0;
        #2;
        chk("mr_op", 64'(op), 64'h0);
        chk("mr_a", 64'(a), 64'h0);
        chk("mr_b", 64'(b), 64'h0);
        chk("mr_busy", 64'(busy), 64'h0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        send_bit(1'b1);
        chk("mr_idle_busy", 64'(busy), 64'h0);
        send_frame(4'hC, 32'h0000_00FF, 32'h8000_0000, 1'b1, oddc);
        chk("mr_f_midframe", 64'(oddc), 64'h0);
        chk("mr_f_valid", 64'(valid), 64'h1);
        chk("mr_f_op", 64'(op), 64'hC);
        chk("mr_f_a", 64'(a), 64'h0000_00FF);
        chk("mr_f_b", 64'(b), 64'h8000_0000);

`ifdef NANOV_LOADER_PARITY_EN
        send_frame(4'h7, 32'h0000_0003, 32'h0000_0001, 1'b1, oddc);
        chk("p_good_valid", 64'(valid), 64'h1);
        chk("p_good_op", 64'(op), 64'h7);
        pflip = 1'b1;
        send_frame(4'h2, 32'h0000_0003, 32'h0000_0001, 1'b1, oddc);
        pflip = 1'b0;
        chk("p_bad_err", 64'(err), 64'h1);
        chk("p_bad_valid", 64'(valid), 64'h0);
        chk("p_bad_keep_op", 64'(op), 64'h7);
`endif

        rx = 1'b1;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nanov_operand_loader.md
# nanov_operand_loader

Serial front end for the nanoV core. Receives one framed bit-serial command on a single input pin at one bit per clock, deserializes it into a 4-bit opcode and two 32-bit operands, checks framing, and presents the result as registered, stable buses with a one-cycle valid strobe. It sits directly upstream of the core's `op`/`a`/`b` inputs and replaces the free-running shift chain with a framed, error-checked loader.

## Interface
- `OP_W`, default 4: opcode width.
- `DATA_W`, default 32: width of each operand.

- `clk12MHz` input 1: the single clock. All logic is on the rising edge.
- `rstn` input 1: reset, asynchronous and active-low.
- `rx_i` input 1: serial data, one bit sampled per rising edge; idle level 1.
- `op_o` output OP_W: last committed opcode.
- `a_o` output DATA_W: last committed operand A.
- `b_o` output DATA_W: last committed operand B.
- `valid_o` output 1: one-cycle pulse; a new frame was committed.
- `busy_o` output 1: a frame is in progress.
- `err_o` output 1: one-cycle pulse; a frame was rejected.

## Operation
- Frame, in order: start bit (0), OP_W opcode bits MSB-first, DATA_W A bits MSB-first, DATA_W B bits MSB-first, optional parity bit (see Configuration), stop bit (1).
- FSM states: IDLE, OP, A, B, PAR (only with the macro), STOP, BREAK.
- IDLE: if `rx_i`=0, go to OP and clear the bit counter. Otherwise stay.
- OP, A, B: shift `rx_i` into the internal shadow registers `op_s`, `a_s` and `b_s`. A 6-bit counter selects the field. Advance to the next field after OP_W, DATA_W and DATA_W bits respectively. After B, go to PAR, or to STOP when parity is compiled out.
- STOP:
  - If `rx_i`=1 and no parity error: copy the shadow registers to `op_o`, `a_o` and `b_o`, pulse `valid_o`, and go to IDLE.
  - Otherwise: pulse `err_o`, leave the outputs unchanged, and go to BREAK.
- BREAK: wait for `rx_i`=1, then go to IDLE. A line held low therefore never starts a new frame.
- `op_o`, `a_o` and `b_o` change only on commit. Between commits they hold their value.
- `busy_o` = 1 in OP, A, B, PAR and STOP. It is 0 in IDLE and BREAK.
- `valid_o` and `err_o` are never high in the same cycle.

## Timing
- Reset values: `op_o`=0, `a_o`=0, `b_o`=0, `valid_o`=0, `busy_o`=0, `err_o`=0. The state is IDLE and the shadow registers are 0.
- Edge numbering: the start bit is sampled at edge 0.
  - Opcode bits are sampled at edges 1..OP_W.
  - A bits follow, then B bits.
  - With defaults and no parity, the stop bit is sampled at edge 69. The frame is 70 bits long.
- Commit latency: the outputs update and `valid_o` is high in the cycle immediately after the stop-bit edge. `valid_o` lasts exactly one cycle.
- Back-to-back frames: a start bit sampled at the edge right after the stop bit (edge 70) is accepted. No idle gap is required.
- `busy_o` rises after edge 0 and falls after the stop-bit edge.
- Reset asserted mid-frame: all state clears immediately and the partial frame is discarded. The outputs read 0 until the next good frame.

## Configuration
- `NANOV_LOADER_PARITY_EN` defined:
  - A PAR state samples one extra bit after B, making the frame 71 bits.
  - The received bit must equal the XOR of all OP_W+2·DATA_W payload bits, i.e. even parity over payload plus parity bit.
  - A mismatch is latched. At STOP it forces `err_o` and no commit, whatever the stop bit is.
- Not defined: there is no PAR state and the frame is 70 bits. The parity logic is absent.

## Test plan
- Reset, then idle line for 10 cycles → all outputs 0, `busy_o`=0, no pulses.
- One good frame, op=4'hA, A=32'h1234_5678, B=32'hDEAD_BEEF → `valid_o` high for one cycle right after edge 69 (edge 70 with parity), with the outputs showing exactly these values. `busy_o` is high for cycles 1..69.
- Two frames back-to-back, second frame op=4'h3, A=32'h0000_0001, B=32'hFFFF_FFFF → two `valid_o` pulses 70 cycles apart, the second carrying the new values.
- Good frame op=4'hA, then a frame with stop bit 0 followed by `rx_i` held low for 20 cycles → `err_o` pulses once, outputs keep op=4'hA, no new frame starts until `rx_i` returns to 1.
- `rstn` pulsed low at edge 40 of a frame → outputs immediately 0, state IDLE. A following full good frame is accepted normally.
- With `NANOV_LOADER_PARITY_EN`: a frame with a correct parity bit → `valid_o`. The same frame with the parity bit inverted → `err_o` and the outputs unchanged.
